power_session_ctrl: RTL and testbench
=====================================

// Module: power_session_ctrl
// PURPOSE
//  Power/session controller for the 8-bit calculator. Debounces the OnOff push-button.
//  Toggles the calculator between OFF and ON, and issues a timed clear to the datapath on power-up.
//  Runs an inactivity auto-off with a warning phase, and gates the WIDTH-bit datapath bus to zero while off.
//  Sits between the board button/keypad and the ALU/display datapath.
// PARAMETERS
//  WIDTH            8     width of gated data bus
//  DB_CYCLES        16    consecutive stable samples required to accept a new button level (>=2)
//  CLR_CYCLES       4     length of clr pulse issued in WAKE (>=1)
//  AUTO_OFF_CYCLES  1000  idle cycles in ON before entering WARN (>=2)
//  WARN_CYCLES      200   cycles in WARN before auto power-off (>=2)
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous, active-high reset
//  onoff_btn     in   1      raw OnOff button, 1 = pressed, asynchronous/bouncy
//  activity      in   1      1-cycle pulse from keypad on any key press (sync to clk)
//  din           in   WIDTH  datapath value to be gated
//  dout          out  WIDTH  registered din while ON/WARN, else 0
//  power_on      out  1      1 in WAKE, ON, WARN
//  clr           out  1      datapath clear, high for exactly CLR_CYCLES cycles in WAKE
//  warn          out  1      1 while in WARN (display blink request)
// BEHAVIOUR
//  - Reset: state=OFF; dout=0; power_on=0; clr=0; warn=0; sync FFs=0; debounced level=0; counters=0.
//  - Button path: 2-FF synchronizer, then debounce counter. Debounced level takes the synced value
//    after DB_CYCLES consecutive equal samples differing from it. Any mismatch restarts the count.
//  - toggle event: 1-cycle pulse on debounced 1->0 (press-and-release); fires DB_CYCLES+2 cycles after raw release.
//  - FSM states OFF, WAKE, ON, WARN; all outputs registered from state; state moves cycle after event.
//    OFF : toggle -> WAKE (clr_cnt=0). activity ignored.
//    WAKE: clr=1; clr_cnt++; after CLR_CYCLES cycles -> ON (idle_cnt=0). toggle -> OFF (abort, clr drops).
//    ON  : idle_cnt++ each cycle; activity -> idle_cnt=0; idle_cnt==AUTO_OFF_CYCLES-1 -> WARN (warn_cnt=0).
//          toggle -> OFF.
//    WARN: warn=1; warn_cnt++; activity -> ON (idle_cnt=0); warn_cnt==WARN_CYCLES-1 -> OFF; toggle -> OFF.
//  - Simultaneous toggle+activity: toggle wins (-> OFF). activity coincident with WARN timeout -> ON.
//  - activity during WAKE ignored; ON idle count starts at 0 on WAKE->ON.
//  - dout <= (state==ON||state==WARN) ? din : 0; one-cycle latency, no wrap or arithmetic on data.
//  - Counters saturate-free: each is cleared on state entry, width = $clog2(max param)+1.
//  - reset mid-operation (any state, mid-debounce) -> reset values next cycle, no clr pulse emitted.
//  - Held button never retoggles. Bounce shorter than DB_CYCLES produces no event.
// STRUCTURE
//  - calc_pkg: state encoding constants PWR_OFF=2'd0, PWR_WAKE=2'd1, PWR_ON=2'd2, PWR_WARN=2'd3;
//    shared WIDTH default (8).
//  - Sub-module button_debounce (clk, reset, raw, level, fall_pulse; param DB_CYCLES) holds sync+counter.
//    It is reusable for the calculator keypad buttons.
//  - Top holds FSM, clr/idle/warn counters and output gating register.
// TESTING (DB_CYCLES=4, CLR_CYCLES=3, AUTO_OFF_CYCLES=20, WARN_CYCLES=5, WIDTH=8)
//  1 reset, din=8'hA5, no press
//    -> dout=0, power_on=0, clr=0, warn=0 for 50 cycles.
//  2 press 10 cycles, release; din=8'h3C
//    -> toggle 6 cycles after release; power_on=1; clr high exactly 3 cycles; then ON; dout=8'h3C next cycle.
//  3 press with 1-3 cycle bounce glitches, then clean press/release
//    -> exactly one WAKE entry; glitches alone produce no event.
//  4 ON, no activity
//    -> WARN after 20 cycles, warn=1 for 5 cycles, then OFF, dout=0.
//    Repeat with activity at WARN cycle 2 -> back to ON, warn=0, idle restarts.
//  5 toggle during WAKE cycle 2
//    -> OFF next cycle, clr=0. Toggle and activity same cycle in ON -> OFF.
//  6 assert reset during WARN and mid-debounce
//    -> all outputs 0 next cycle; held button after reset release gives no toggle until released.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator power/session logic.
package calc_pkg;

   localparam int unsigned CALC_WIDTH = 8;

   localparam logic [1:0] PWR_OFF  = 2'd0;
   localparam logic [1:0] PWR_WAKE = 2'd1;
   localparam logic [1:0] PWR_ON   = 2'd2;
   localparam logic [1:0] PWR_WARN = 2'd3;

   typedef enum logic [1:0] {
      StOff  = PWR_OFF,
      StWake = PWR_WAKE,
      StOn   = PWR_ON,
      StWarn = PWR_WARN
   } pwr_state_e;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stable-sample debouncer for a push-button.
// Emits a one-cycle pulse on a debounced release (1->0).
module button_debounce #(
   parameter int unsigned DB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic fall_pulse
);

   localparam int unsigned CW = $clog2(DB_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         cnt_q      <= '0;
         level      <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         sync1_q    <= raw;
         sync2_q    <= sync1_q;
         fall_pulse <= 1'b0;
         // Count consecutive samples disagreeing with the accepted level.
         if (sync2_q != level) begin
            if (cnt_q == CNT_LAST) begin
               level      <= sync2_q;
               cnt_q      <= '0;
               fall_pulse <= ~sync2_q;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

endmodule

// File: rtl/power_session_ctrl.sv
// Power/session controller: button toggles OFF/ON, timed clear on wake,
// inactivity auto-off with a warning phase, and datapath gating while off.
module power_session_ctrl
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH           = CALC_WIDTH,
   parameter int unsigned DB_CYCLES       = 16,
   parameter int unsigned CLR_CYCLES      = 4,
   parameter int unsigned AUTO_OFF_CYCLES = 1000,
   parameter int unsigned WARN_CYCLES     = 200
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             onoff_btn,
   input  logic             activity,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             power_on,
   output logic             clr,
   output logic             warn
);

   localparam int unsigned CNT_MAX = max3(CLR_CYCLES, AUTO_OFF_CYCLES, WARN_CYCLES);
   localparam int unsigned CW      = $clog2(CNT_MAX) + 1;

   localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);
   localparam logic [CW-1:0] IDLE_LAST = CW'(AUTO_OFF_CYCLES - 1);
   localparam logic [CW-1:0] WARN_LAST = CW'(WARN_CYCLES - 1);

   logic btn_level;
   logic btn_fall;
   logic toggle;

   button_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_btn_db (
      .clk        (clk),
      .reset      (reset),
      .raw        (onoff_btn),
      .level      (btn_level),
      .fall_pulse (btn_fall)
   );

   // A genuine release leaves the debounced level low.
   assign toggle = btn_fall & ~btn_level;

   pwr_state_e    state_q;
   logic [CW-1:0] clr_cnt_q;
   logic [CW-1:0] idle_cnt_q;
   logic [CW-1:0] warn_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StOff;
         clr_cnt_q  <= '0;
         idle_cnt_q <= '0;
         warn_cnt_q <= '0;
         power_on   <= 1'b0;
         clr        <= 1'b0;
         warn       <= 1'b0;
         dout       <= '0;
      end else begin
         dout <= (state_q == StOn || state_q == StWarn) ? din : '0;
         // Outputs are updated alongside each transition so they track state_q exactly.
         unique case (state_q)
            StOff: begin
               if (toggle) begin
                  state_q   <= StWake;
                  clr_cnt_q <= '0;
                  power_on  <= 1'b1;
                  clr       <= 1'b1;
               end
            end
            StWake: begin
               if (toggle) begin
                  state_q  <= StOff;
                  power_on <= 1'b0;
                  clr      <= 1'b0;
               end else if (clr_cnt_q == CLR_LAST) begin
                  state_q    <= StOn;
                  idle_cnt_q <= '0;
                  clr        <= 1'b0;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            StOn: begin
               if (toggle) begin
                  state_q  <= StOff;
                  power_on <= 1'b0;
               end else if (activity) begin
                  idle_cnt_q <= '0;
               end else if (idle_cnt_q == IDLE_LAST) begin
                  state_q    <= StWarn;
                  warn_cnt_q <= '0;
                  warn       <= 1'b1;
               end else begin
                  idle_cnt_q <= idle_cnt_q + 1'b1;
               end
            end
            StWarn: begin
               if (toggle) begin
                  state_q  <= StOff;
                  power_on <= 1'b0;
                  warn     <= 1'b0;
               end else if (activity) begin
                  state_q    <= StOn;
                  idle_cnt_q <= '0;
                  warn       <= 1'b0;
               end else if (warn_cnt_q == WARN_LAST) begin
                  state_q  <= StOff;
                  power_on <= 1'b0;
                  warn     <= 1'b0;
               end else begin
                  warn_cnt_q <= warn_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q  <= StOff;
               power_on <= 1'b0;
               clr      <= 1'b0;
               warn     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_power_session_ctrl.sv
// Bench for power_session_ctrl: two instances (short and long clear phase) driven in
// parallel and compared every cycle against a deadline-based behavioural model.
module tb_power_session_ctrl;

   localparam int DB    = 4;
   localparam int CLR_A = 3;
   localparam int CLR_B = 16;
   localparam int AUTO  = 20;
   localparam int WARNC = 5;

   localparam int S_OFF  = 0;
   localparam int S_WAKE = 1;
   localparam int S_ON   = 2;
   localparam int S_WARN = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       onoff_btn = 1'b0;
   logic       activity = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] dout_a, dout_b;
   logic       power_on_a, power_on_b, clr_a, clr_b, warn_a, warn_b;

   power_session_ctrl #(
      .WIDTH(8), .DB_CYCLES(DB), .CLR_CYCLES(CLR_A), .AUTO_OFF_CYCLES(AUTO), .WARN_CYCLES(WARNC)
   ) dut_a (
      .clk(clk), .reset(reset), .onoff_btn(onoff_btn), .activity(activity), .din(din),
      .dout(dout_a), .power_on(power_on_a), .clr(clr_a), .warn(warn_a)
   );

   power_session_ctrl #(
      .WIDTH(8), .DB_CYCLES(DB), .CLR_CYCLES(CLR_B), .AUTO_OFF_CYCLES(AUTO), .WARN_CYCLES(WARNC)
   ) dut_b (
      .clk(clk), .reset(reset), .onoff_btn(onoff_btn), .activity(activity), .din(din),
      .dout(dout_b), .power_on(power_on_b), .clr(clr_b), .warn(warn_b)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: sync pipe, window of recent samples, per-instance state + deadline.
   int   cyc = 0;
   bit   m_s1 = 0, m_s2 = 0, m_lvl = 0, m_tog = 0;
   bit   m_hist[$];
   int   m_st[2] = '{S_OFF, S_OFF};
   int   m_dl[2] = '{0, 0};
   logic [7:0] m_dout[2] = '{8'h00, 8'h00};

   int clr_seen = 0, warn_seen = 0, wake_a = 0;
   bit prev_clr_a = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_step();
      bit all_diff;
      int clr_len;
      cyc++;
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_lvl = 0; m_tog = 0;
         m_hist.delete();
         for (int i = 0; i < 2; i++) begin
            m_st[i] = S_OFF;
            m_dout[i] = 8'h00;
         end
         return;
      end
      for (int i = 0; i < 2; i++) begin
         clr_len = (i == 0) ? CLR_A : CLR_B;
         m_dout[i] = (m_st[i] == S_ON || m_st[i] == S_WARN) ? din : 8'h00;
         case (m_st[i])
            S_OFF:  if (m_tog) begin m_st[i] = S_WAKE; m_dl[i] = cyc + clr_len; end
            S_WAKE: if (m_tog) m_st[i] = S_OFF;
                    else if (cyc == m_dl[i]) begin m_st[i] = S_ON; m_dl[i] = cyc + AUTO; end
            S_ON:   if (m_tog) m_st[i] = S_OFF;
                    else if (activity) m_dl[i] = cyc + AUTO;
                    else if (cyc == m_dl[i]) begin m_st[i] = S_WARN; m_dl[i] = cyc + WARNC; end
            default: if (m_tog) m_st[i] = S_OFF;
                    else if (activity) begin m_st[i] = S_ON; m_dl[i] = cyc + AUTO; end
                    else if (cyc == m_dl[i]) m_st[i] = S_OFF;
         endcase
      end
      // New level accepted once the last DB synced samples all disagree with it.
      m_hist.push_back(m_s2);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      all_diff = (m_hist.size() == DB);
      foreach (m_hist[k]) if (m_hist[k] == m_lvl) all_diff = 0;
      m_tog = 0;
      if (all_diff) begin
         m_lvl = !m_lvl;
         m_tog = !m_lvl;
      end
      m_s2 = m_s1;
      m_s1 = onoff_btn;
   endtask

   task automatic compare_all();
      check("a.power_on", 32'(power_on_a), 32'(m_st[0] != S_OFF));
      check("a.clr",      32'(clr_a),      32'(m_st[0] == S_WAKE));
      check("a.warn",     32'(warn_a),     32'(m_st[0] == S_WARN));
      check("a.dout",     32'(dout_a),     32'(m_dout[0]));
      check("b.power_on", 32'(power_on_b), 32'(m_st[1] != S_OFF));
      check("b.clr",      32'(clr_b),      32'(m_st[1] == S_WAKE));
      check("b.warn",     32'(warn_b),     32'(m_st[1] == S_WARN));
      check("b.dout",     32'(dout_b),     32'(m_dout[1]));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      if (clr_a === 1'b1) clr_seen++;
      if (warn_a === 1'b1) warn_seen++;
      if (clr_a === 1'b1 && !prev_clr_a) wake_a++;
      prev_clr_a = (clr_a === 1'b1);
   endtask

   task automatic run(input int n, input bit rnd_din);
      for (int i = 0; i < n; i++) begin
         if (rnd_din) din = 8'($urandom());
         step();
      end
   endtask

   task automatic press(input int hold, input int after);
      onoff_btn = 1'b1;
      run(hold, 1);
      onoff_btn = 1'b0;
      run(after, 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run(2, 1);
      reset = 1'b0;
   endtask

   task automatic wait_warn_a(input string tag);
      int k;
      k = 0;
      while (warn_a !== 1'b1 && k < 60) begin
         step();
         k++;
      end
      check(tag, 32'(warn_a), 32'd1);
   endtask

   initial begin
      int k;
      // 1: reset, no press, datapath stays gated
      din = 8'hA5;
      reset = 1'b1;
      run(2, 0);
      reset = 1'b0;
      run(50, 0);
      check("t1.dout_gated", 32'(dout_a), 32'h0);

      // 2: clean press/release, toggle latency, clr length, dout passes din
      din = 8'h3C;
      onoff_btn = 1'b1;
      run(10, 0);
      onoff_btn = 1'b0;
      clr_seen = 0;
      k = 0;
      while (power_on_a !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      check("t2.on_latency", 32'(k), 32'd7);
      run(15, 0);
      check("t2.clr_len", 32'(clr_seen), 32'(CLR_A));
      check("t2.dout", 32'(dout_a), 32'h3C);

      // 3: bounce glitches give no event, then one clean press gives one wake
      do_reset();
      wake_a = 0;
      for (int g = 0; g < 4; g++) begin
         onoff_btn = 1'b1;
         run($urandom_range(1, 3), 1);
         onoff_btn = 1'b0;
         run(6, 1);
      end
      check("t3.glitch_off", 32'(power_on_a), 32'd0);
      check("t3.glitch_nowake", 32'(wake_a), 32'd0);
      press(8, 12);
      check("t3.one_wake", 32'(wake_a), 32'd1);

      // 4: idle -> WARN for WARNC cycles -> OFF; then rescue from WARN by activity
      warn_seen = 0;
      run(40, 1);
      check("t4.warn_len", 32'(warn_seen), 32'(WARNC));
      check("t4.auto_off", 32'(power_on_a), 32'd0);
      check("t4.dout_off", 32'(dout_a), 32'h0);
      press(8, 12);
      wait_warn_a("t4.reach_warn");
      step();
      activity = 1'b1;
      step();
      activity = 1'b0;
      check("t4.rescue_warn", 32'(warn_a), 32'd0);
      check("t4.rescue_on", 32'(power_on_a), 32'd1);
      run(AUTO - 1, 1);
      check("t4.idle_restart", 32'(warn_a), 32'd0);
      step();
      check("t4.rewarn", 32'(warn_a), 32'd1);

      // 5: second toggle aborts long WAKE; toggle with activity in ON powers off
      do_reset();
      onoff_btn = 1'b1; run(8, 1);
      onoff_btn = 1'b0; run(5, 1);
      onoff_btn = 1'b1; run(6, 1);
      onoff_btn = 1'b0; run(12, 1);
      check("t5.wake_abort", 32'(power_on_b), 32'd0);
      check("t5.wake_abort_clr", 32'(clr_b), 32'd0);
      press(8, 15);
      onoff_btn = 1'b1;
      run(8, 1);
      onoff_btn = 1'b0;
      activity = 1'b1;
      run(10, 1);
      activity = 1'b0;
      check("t5.toggle_beats_act", 32'(power_on_a), 32'd0);

      // 6: reset during WARN with button mid-debounce; held button must not toggle
      press(8, 12);
      wait_warn_a("t6.reach_warn");
      onoff_btn = 1'b1;
      run(2, 1);
      reset = 1'b1;
      step();
      check("t6.rst_power_on", 32'(power_on_a), 32'd0);
      check("t6.rst_warn", 32'(warn_a), 32'd0);
      check("t6.rst_clr", 32'(clr_a), 32'd0);
      check("t6.rst_dout", 32'(dout_a), 32'h0);
      reset = 1'b0;
      run(30, 1);
      check("t6.held_no_toggle", 32'(power_on_a), 32'd0);
      onoff_btn = 1'b0;
      run(10, 1);
      check("t6.release_toggles", 32'(power_on_a), 32'd1);

      // Randomized mix of button levels, sparse activity and data
      do_reset();
      for (int s = 0; s < 60; s++) begin
         onoff_btn = 1'($urandom_range(0, 1));
         for (int c = 0; c < int'($urandom_range(1, 14)); c++) begin
            activity = ($urandom_range(0, 15) == 0);
            din = 8'($urandom());
            step();
         end
      end
      activity = 1'b0;
      run(5, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
